spi_sample_rx: RTL and testbench

- SPI responder (slave) for the FPGA-to-Pi sample link. It is the receive end of the stream in which the master sends one sign-magnitude sample per 48 kHz frame (833 clk cycles).
- Used on the second board of a two-FPGA chain, and as the self-checking loopback monitor on the multi-effects board. There, sclkPi, doutPi and ncsPi are fed back into it.
- Oversamples the SPI pins on the 40 MHz system clock, rebuilds each frame, checks framing, and presents a sample with a one-cycle valid strobe.

---
 rtl/fpga_pkg.sv | 15 +
 rtl/spi_sample_rx_if.sv | 11 +
 rtl/sync_edge.sv | 24 ++
 rtl/spi_sample_rx.sv | 100 ++++++++++
 tb/tb_spi_sample_rx.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fpga_pkg.sv
// fpga_pkg: shared types, constants and sample conversion for the FPGA sample path.
//   rx_state_t   : receive FSM states
//   SAMPLE_W     : sign-magnitude sample width
//   FRAME_PERIOD : clk cycles per 48 kHz frame
//   sm_to_tc()   : sign-magnitude to two's complement (negative zero -> 0)
package fpga_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;
    localparam int SAMPLE_W = 11;
    localparam int FRAME_PERIOD = 833;
    function automatic logic [SAMPLE_W-1:0] sm_to_tc(input logic [SAMPLE_W-1:0] sm);
        logic [SAMPLE_W-1:0] mag;
        mag = {1'b0, sm[SAMPLE_W-2:0]};
        return sm[SAMPLE_W-1] ? -mag : mag;
    endfunction
endpackage

// File: rtl/spi_sample_rx_if.sv
// spi_sample_rx_if: SPI sample link pins.
//   sclk : serial clock from master
//   din  : MOSI, MSB first, valid on sclk rising edge
//   ncs  : chip select, active low
interface spi_sample_rx_if;
    logic sclk;
    logic din;
    logic ncs;
    modport master (output sclk, din, ncs);
    modport slave (input sclk, din, ncs);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer plus history flop with edge detect.
//   clk, reset : system clock, async active-low reset (flops preset to INIT)
//   d          : asynchronous input
//   lvl        : synchronized level
//   rise, fall : one-cycle edge strobes on the synchronized level
module sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic s1, s2, h;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) {s1, s2, h} <= {3{INIT}};
        else {s1, s2, h} <= {d, s1, s2};
    end
    assign lvl = s2;
    assign rise = s2 & ~h;
    assign fall = ~s2 & h;
endmodule

// File: rtl/spi_sample_rx.sv
// spi_sample_rx: SPI responder that rebuilds one sign-magnitude sample per frame.
//   clk, reset : 40 MHz system clock, async active-low reset
//   spi        : SPI pins (slave modport: sclk, din, ncs)
//   sample     : last good sample
//   valid      : one-cycle pulse when sample updates
//   frame_err  : one-cycle pulse on a short/long or timed-out frame
//   err_count  : saturating frame error count
//   busy       : high while shifting a frame
// Define SPI_RX_TWOS_COMP_EN to deliver samples as two's complement.
module spi_sample_rx
    import fpga_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int FRAME_BITS = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    spi_sample_rx_if.slave    spi,
    output logic [DATA_W-1:0] sample,
    output logic              valid,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    // Watchdog limit never drops below one frame period, so a healthy frame cannot trip it.
    localparam int WD_LIM = TIMEOUT > FRAME_PERIOD ? TIMEOUT : FRAME_PERIOD + 1;
    localparam int WD_W = $clog2(WD_LIM + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic din_lvl, din_rise, din_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic unused_edges;
    rx_state_t state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0] wd;
    logic [DATA_W-1:0] sh, conv;
    logic from_check, start, tmo, good, bad;

    sync_edge #(.INIT(1'b0)) u_sclk (.clk(clk), .reset(reset), .d(spi.sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge #(.INIT(1'b0)) u_din (.clk(clk), .reset(reset), .d(spi.din), .lvl(din_lvl), .rise(din_rise), .fall(din_fall));
    sync_edge #(.INIT(1'b1)) u_ncs (.clk(clk), .reset(reset), .d(spi.ncs), .lvl(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));
    assign unused_edges = ^{sclk_lvl, sclk_fall, din_rise, din_fall};

`ifdef SPI_RX_TWOS_COMP_EN
    assign conv = sm_to_tc(sh);
`else
    assign conv = sh;
`endif

    assign busy = state == SHIFT;

    // An ncs fall seen during CHECK leaves ncs low on the first IDLE cycle; treat that as a start.
    always_comb begin
        start = state == IDLE && (ncs_fall || (from_check && !ncs_lvl));
        tmo = state == SHIFT && !ncs_rise && wd == WD_W'(WD_LIM - 1);
        good = state == CHECK && cnt == CNT_W'(FRAME_BITS);
        bad = tmo || (state == CHECK && cnt != CNT_W'(FRAME_BITS));
        state_d = start ? SHIFT
                : state == SHIFT ? (ncs_rise ? CHECK : tmo ? IDLE : SHIFT)
                : state == CHECK ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            from_check <= 1'b0;
        end else begin
            state <= state_d;
            from_check <= state == CHECK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            wd <= '0;
            sh <= '0;
            sample <= '0;
            valid <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            valid <= good;
            frame_err <= bad;
            if (start) begin
                cnt <= '0;
                wd <= '0;
            end else if (state == SHIFT) begin
                wd <= wd + 1'b1;
                if (sclk_rise && cnt != CNT_W'(FRAME_BITS + 1)) cnt <= cnt + 1'b1;
            end
            // Shifting is independent of the transition so a bit coinciding with ncs rise is kept.
            if (state == SHIFT && sclk_rise) sh <= {sh[DATA_W-2:0], din_lvl};
            if (good) sample <= conv;
            if (bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_spi_sample_rx.sv
// tb_spi_sample_rx: scoreboard bench for spi_sample_rx (honours SPI_RX_TWOS_COMP_EN).
module tb_spi_sample_rx;
    typedef struct {
        logic        err;
        logic [10:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [10:0] sample;
    logic valid, frame_err, busy;
    logic [7:0] err_count;
    int total = 0;
    int bad = 0;
    exp_t q[$];
    logic [10:0] last = '0;

    spi_sample_rx_if bus();

    spi_sample_rx dut (
        .clk(clk), .reset(reset), .spi(bus), .sample(sample), .valid(valid),
        .frame_err(frame_err), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] model(input logic [15:0] w);
        int v;
        v = int'(w[9:0]);
`ifdef SPI_RX_TWOS_COMP_EN
        if (w[10]) v = -v;
`else
        if (w[10]) v = v + 1024;
`endif
        return 11'(v);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] w, input int n, input int half, input int gap, input bit meas);
        exp_t e;
        int k;
        e.err = n != 16;
        e.val = n == 16 ? model(w) : last;
        last = e.val;
        q.push_back(e);
        bus.ncs = 1'b0;
        cyc(2);
        for (int i = 0; i < n; i++) begin
            bus.din = w[15-i];
            cyc(half);
            bus.sclk = 1'b1;
            if (i != n - 1) begin
                cyc(half);
                bus.sclk = 1'b0;
            end
        end
        cyc(2);
        if (meas) chk("busy_mid", busy, 1);
        bus.sclk = 1'b0;
        bus.ncs = 1'b1;
        if (meas) begin
            k = 1;
            while (k <= 10) begin
                cyc(1);
                if (valid) break;
                k++;
            end
            chk("latency", k, 4);
            chk("busy_idle", busy, 0);
        end
        cyc(gap);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && (valid || frame_err)) begin
            chk("excl", valid & frame_err, 0);
            if (q.size() == 0) chk("unexpected", 1, 0);
            else begin
                e = q.pop_front();
                chk("kind", frame_err, e.err);
                chk("sample", sample, e.val);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int at;
        bus.sclk = 1'b0;
        bus.din = 1'b0;
        bus.ncs = 1'b1;
        cyc(3);
        chk("rst_sample", sample, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_cnt", err_count, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        cyc(3);
        send(16'h0123, 16, 32, 20, 1);
        send(16'h0405, 16, 8, 20, 0);
        send(16'h0400, 16, 8, 20, 0);
        send(16'hABCD, 12, 8, 20, 0);
        chk("errcnt_short", err_count, 1);
        // ncs held low 1100 cycles with 10 edges: watchdog abort
        q.push_back('{1'b1, last});
        bus.ncs = 1'b0;
        at = -1;
        for (int c = 0; c < 1100; c++) begin
            cyc(1);
            bus.sclk = c < 160 && (c % 16) >= 8;
            bus.din = 1'($urandom);
            if (frame_err && at < 0) at = c;
        end
        chk("tmo_window", at >= 1015 && at <= 1035, 1);
        bus.sclk = 1'b0;
        bus.ncs = 1'b1;
        cyc(20);
        chk("errcnt_tmo", err_count, 2);
        send(16'h07FF, 16, 8, 20, 0);
        // reset in the middle of a frame
        bus.ncs = 1'b0;
        cyc(2);
        for (int i = 0; i < 8; i++) begin
            bus.din = 1'(i);
            cyc(8);
            bus.sclk = 1'b1;
            cyc(8);
            bus.sclk = 1'b0;
        end
        reset = 1'b0;
        bus.ncs = 1'b1;
        #2;
        chk("mid_rst_sample", sample, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_err", frame_err, 0);
        chk("mid_rst_cnt", err_count, 0);
        chk("mid_rst_busy", busy, 0);
        last = '0;
        cyc(3);
        reset = 1'b1;
        cyc(3);
        send(16'h0055, 16, 8, 20, 0);
        chk("errcnt_after_rst", err_count, 0);
        send(16'h0321, 16, 8, 1, 0);
        send(16'h0456, 16, 8, 2, 0);
        send(16'h0789, 16, 8, 20, 0);
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 0) send(16'($urandom), 16, 8, 2, 0);
            send(16'($urandom), 4, 8, 2, 0);
        end
        cyc(20);
        for (int i = 0; i < 200 && q.size() > 0; i++) cyc(1);
        chk("drain", q.size(), 0);
        chk("errcnt_sat", err_count, 255);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
